// File: rtl/riscv_pkg.sv
// Shared RV32I memory-access definitions.
// Provides the responder state encoding and the load/store funct3 codes
// used by the data-memory responder and its lane-alignment helper.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Access size/sign encodings (stores reuse the LB/LH/LW codes).
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for RV32I loads and stores.
// Ports:
//   we     - 1 = store, 0 = load
//   funct3 - access size/sign
//   lane   - byte offset within the word (addr[1:0])
//   wdata  - right-aligned store data
//   rword  - full 32-bit word read from storage
//   be     - byte enables for a legal store (all zero for loads/faults)
//   wword  - store data replicated onto the addressed lanes
//   rdata  - extended load result
//   fault  - illegal funct3, store-only illegal code, or misalignment
module lsu_align
  import riscv_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        fault
);

  // Addressed byte/halfword moved down to bit 0.
  logic [15:0] shifted;

  always_comb begin
    shifted = 16'(rword >> {lane, 3'b000});
    be      = 4'b0000;
    wword   = 32'h0;
    rdata   = 32'h0;
    fault   = 1'b0;
    case (funct3)
      FUNCT3_LB: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata[7:0]}};
        rdata = {{24{shifted[7]}}, shifted[7:0]};
      end
      FUNCT3_LBU: begin
        fault = we;
        rdata = {24'h0, shifted[7:0]};
      end
      FUNCT3_LH: begin
        fault = lane[0];
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = {{16{shifted[15]}}, shifted};
      end
      FUNCT3_LHU: begin
        fault = we | lane[0];
        rdata = {16'h0, shifted};
      end
      FUNCT3_LW: begin
        fault = (lane != 2'b00);
        be    = 4'b1111;
        wword = wdata;
        rdata = rword;
      end
      default: fault = 1'b1;
    endcase
    // Loads and faulting stores never enable a lane.
    if (!we || fault) be = 4'b0000;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for an RV32I MEM stage.
// Accepts one request at a time (valid/ready), waits WAIT_STATES cycles,
// then presents a response held until consumed (valid/ready).
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   req_valid/req_ready         - request handshake
//   req_we/req_funct3/req_addr/req_wdata - request contents
//   rsp_valid/rsp_ready         - response handshake
//   rsp_rdata/rsp_err           - load result / access fault
//   busy                        - high whenever not IDLE (pipeline stall)
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int ENTRY_COUNT = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int IDX_W = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;

  mem_state_t  state, state_next;
  logic [2:0]  count;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [ENTRY_COUNT];

  logic        handshake, enter_resp, in_range, access_err;
  logic        eff_we;
  logic [2:0]  eff_funct3;
  logic [31:0] eff_addr, eff_wdata, rword;
  logic [29:0] word_index;
  logic [IDX_W-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wword, ext_rdata;
  logic        fault;

  assign handshake = req_valid && (state == IDLE);

  // With zero wait states the commit edge is the handshake edge itself, so
  // the live request is used in IDLE and the captured copy afterwards.
  assign eff_we     = (state == IDLE) ? req_we     : we_q;
  assign eff_funct3 = (state == IDLE) ? req_funct3 : funct3_q;
  assign eff_addr   = (state == IDLE) ? req_addr   : addr_q;
  assign eff_wdata  = (state == IDLE) ? req_wdata  : wdata_q;

  assign word_index = eff_addr[31:2];
  assign in_range   = ({2'b00, word_index} < 32'(ENTRY_COUNT));
  assign idx        = word_index[IDX_W-1:0];
  assign rword      = in_range ? mem[idx] : 32'h0;

  lsu_align u_align (
    .we     (eff_we),
    .funct3 (eff_funct3),
    .lane   (eff_addr[1:0]),
    .wdata  (eff_wdata),
    .rword  (rword),
    .be     (be),
    .wword  (wword),
    .rdata  (ext_rdata),
    .fault  (fault)
  );

  assign access_err = fault || !in_range;
  assign enter_resp = (state_next == RESP) && (state != RESP);

  // State register and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= 3'd0;
    end else begin
      state <= state_next;
      if (handshake && (WAIT_STATES > 0))
        count <= 3'(WAIT_STATES - 1);
      else if ((state == WAIT) && (count != 3'd0))
        count <= count - 3'd1;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT:    if (count == 3'd0) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

  // Request capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
    end else if (handshake) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end
  end

  // Response registers: sampled once on the edge that enters RESP and held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      err_q   <= access_err;
      rdata_q <= (access_err || eff_we) ? 32'h0 : ext_rdata;
    end
  end

  // Storage: cleared by reset, so it is built from registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_COUNT; i++) mem[i] <= 32'h0;
    end else if (enter_resp && !access_err) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][b*8 +: 8] <= wword[b*8 +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst0, sel;
  logic        req_valid, req_we, rsp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;

  logic        req_valid1, req_valid0;
  logic        req_ready1, req_ready0, rsp_valid1, rsp_valid0;
  logic        rsp_err1, rsp_err0, busy1, busy0;
  logic [31:0] rsp_rdata1, rsp_rdata0;

  logic        req_ready_m, rsp_valid_m, rsp_err_m, busy_m;
  logic [31:0] rsp_rdata_m;

  // sel=1 drives the one-wait-state instance, sel=0 the zero-wait instance.
  assign req_valid1 = req_valid & sel;
  assign req_valid0 = req_valid & ~sel;
  assign req_ready_m = sel ? req_ready1 : req_ready0;
  assign rsp_valid_m = sel ? rsp_valid1 : rsp_valid0;
  assign rsp_err_m   = sel ? rsp_err1   : rsp_err0;
  assign busy_m      = sel ? busy1      : busy0;
  assign rsp_rdata_m = sel ? rsp_rdata1 : rsp_rdata0;

  dmem_responder #(.ENTRY_COUNT(32), .WAIT_STATES(1)) dut1 (
    .clk(clk), .rst(rst1), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .busy(busy1)
  );

  dmem_responder #(.ENTRY_COUNT(32), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst0), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .busy(busy0)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input logic er);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd; v.err = er;
    return v;
  endfunction

  // One request/response; lat counts edges from the handshake edge (as 1)
  // to the edge after which rsp_valid is seen high.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er,
                     output int lat);
    int n;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_valid = 1'b1; rsp_ready = 1'b1;
    n = 0;
    while (!req_ready_m && n < 20) begin @(negedge clk); n++; end
    if (!req_ready_m) check("req_ready_timeout", 32'(req_ready_m), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1; n = 0;
    @(negedge clk);
    while (!rsp_valid_m && n < 20) begin @(negedge clk); lat++; n++; end
    rd = rsp_rdata_m;
    er = rsp_err_m;
    @(posedge clk);
    #1;
  endtask

  vec_t        vecs[$];
  vec_t        v;
  logic [31:0] rd;
  logic        er;
  int          lat;
  int          k;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b1; rst1 = 1'b1; rst0 = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state for both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check($sformatf("reset_req_ready_%0d", s), 32'(req_ready_m), 32'd1);
      check($sformatf("reset_rsp_valid_%0d", s), 32'(rsp_valid_m), 32'd0);
      check($sformatf("reset_busy_%0d", s), 32'(busy_m), 32'd0);
      check($sformatf("reset_rdata_%0d", s), rsp_rdata_m, 32'd0);
      check($sformatf("reset_err_%0d", s), 32'(rsp_err_m), 32'd0);
      $display("reset sel=%0d ready=%0b valid=%0b busy=%0b", s, req_ready_m, rsp_valid_m, busy_m);
    end
    @(negedge clk);
    rst1 = 1'b0; rst0 = 1'b0;
    sel = 1'b1;

    // Directed vectors against the one-wait-state instance
    vecs.push_back(mk(1, FUNCT3_LW,  32'h10, 32'hDEADBEEF, 32'h0, 0));
    vecs.push_back(mk(0, FUNCT3_LW,  32'h10, 32'h0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, FUNCT3_LB,  32'h11, 32'h00000080, 32'h0, 0));
    vecs.push_back(mk(0, FUNCT3_LB,  32'h11, 32'h0, 32'hFFFFFF80, 0));
    vecs.push_back(mk(0, FUNCT3_LBU, 32'h11, 32'h0, 32'h00000080, 0));
    vecs.push_back(mk(0, FUNCT3_LW,  32'h10, 32'h0, 32'hDEAD80EF, 0));
    vecs.push_back(mk(0, FUNCT3_LH,  32'h13, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, FUNCT3_LW,  32'h80, 32'h55555555, 32'h0, 1));
    vecs.push_back(mk(0, FUNCT3_LW,  32'h7C, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, FUNCT3_LW,  32'h00, 32'h0, 32'h0, 0));
    vecs.push_back(mk(1, FUNCT3_LH,  32'h12, 32'h1234ABCD, 32'h0, 0));
    vecs.push_back(mk(0, FUNCT3_LH,  32'h12, 32'h0, 32'hFFFFABCD, 0));
    vecs.push_back(mk(0, FUNCT3_LHU, 32'h12, 32'h0, 32'h0000ABCD, 0));
    vecs.push_back(mk(0, FUNCT3_LB,  32'h10, 32'h0, 32'hFFFFFFEF, 0));
    vecs.push_back(mk(0, FUNCT3_LB,  32'h13, 32'h0, 32'hFFFFFFAB, 0));
    vecs.push_back(mk(0, FUNCT3_LH,  32'h10, 32'h0, 32'hFFFF80EF, 0));
    vecs.push_back(mk(0, FUNCT3_LHU, 32'h11, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, FUNCT3_LW,  32'h12, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, FUNCT3_LBU, 32'h10, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, FUNCT3_LHU, 32'h10, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 3'b011,     32'h10, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 3'b110,     32'h10, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, FUNCT3_LW,  32'hFFFFFFFC, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, FUNCT3_LW,  32'h10, 32'h0, 32'hABCD80EF, 0));
    vecs.push_back(mk(1, FUNCT3_LB,  32'h7F, 32'h123456FE, 32'h0, 0));
    vecs.push_back(mk(0, FUNCT3_LW,  32'h7C, 32'h0, 32'hFE000000, 0));
    vecs.push_back(mk(0, FUNCT3_LBU, 32'h7F, 32'h0, 32'h000000FE, 0));

    foreach (vecs[i]) begin
      v = vecs[i];
      txn(v.we, v.f3, v.addr, v.wdata, rd, er, lat);
      $display("ws1 vec %0d we=%0b f3=%03b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d (want %h %0b 2)",
               i, v.we, v.f3, v.addr, v.wdata, rd, er, lat, v.rdata, v.err);
      check($sformatf("vec%0d_rdata", i), rd, v.rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(v.err));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
    end

    // Response held with rsp_ready low; a competing request must be ignored
    @(negedge clk);
    req_we = 1'b0; req_funct3 = FUNCT3_LW; req_addr = 32'h10; req_wdata = 32'h0;
    req_valid = 1'b1; rsp_ready = 1'b0;
    check("hold_ready_idle", 32'(req_ready_m), 32'd1);
    @(posedge clk);
    #1 req_we = 1'b1; req_wdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("hold_valid_start", 32'(rsp_valid_m), 32'd1);
    check("hold_rdata_start", rsp_rdata_m, 32'hABCD80EF);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      $display("hold cycle %0d valid=%0b rdata=%h req_ready=%0b busy=%0b", c, rsp_valid_m, rsp_rdata_m, req_ready_m, busy_m);
      check($sformatf("hold%0d_valid", c), 32'(rsp_valid_m), 32'd1);
      check($sformatf("hold%0d_rdata", c), rsp_rdata_m, 32'hABCD80EF);
      check($sformatf("hold%0d_req_ready", c), 32'(req_ready_m), 32'd0);
      check($sformatf("hold%0d_busy", c), 32'(busy_m), 32'd1);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_release_valid", 32'(rsp_valid_m), 32'd0);
    check("hold_release_ready", 32'(req_ready_m), 32'd1);
    txn(1'b0, FUNCT3_LW, 32'h10, 32'h0, rd, er, lat);
    $display("ws1 LW 0x10 after hold -> rdata=%h err=%0b lat=%0d", rd, er, lat);
    check("hold_store_ignored", rd, 32'hABCD80EF);

    // Reset while waiting on a store
    @(negedge clk);
    req_we = 1'b1; req_funct3 = FUNCT3_LW; req_addr = 32'h4; req_wdata = 32'h1234;
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("wait_busy", 32'(busy_m), 32'd1);
    check("wait_rsp_valid", 32'(rsp_valid_m), 32'd0);
    rst1 = 1'b1;
    #1;
    $display("reset in WAIT -> ready=%0b busy=%0b valid=%0b", req_ready_m, busy_m, rsp_valid_m);
    check("rstwait_busy", 32'(busy_m), 32'd0);
    check("rstwait_ready", 32'(req_ready_m), 32'd1);
    check("rstwait_valid", 32'(rsp_valid_m), 32'd0);
    @(negedge clk);
    rst1 = 1'b0;
    txn(1'b0, FUNCT3_LW, 32'h4, 32'h0, rd, er, lat);
    $display("ws1 LW 0x4 after reset -> rdata=%h err=%0b lat=%0d", rd, er, lat);
    check("rstwait_store_dropped", rd, 32'h0);
    check("rstwait_lw_lat", 32'(lat), 32'd2);
    txn(1'b0, FUNCT3_LW, 32'h10, 32'h0, rd, er, lat);
    $display("ws1 LW 0x10 after reset -> rdata=%h err=%0b lat=%0d", rd, er, lat);
    check("rst_clears_storage", rd, 32'h0);

    // Zero wait states: back-to-back stores with valid held high
    sel = 1'b0;
    k = 0;
    rsp_ready = 1'b1;
    req_we = 1'b1; req_funct3 = FUNCT3_LW;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("b2b%0d_req_ready", i), 32'(req_ready_m), 32'((i % 2) == 0));
      check($sformatf("b2b%0d_rsp_valid", i), 32'(rsp_valid_m), 32'((i % 2) == 1));
      if (rsp_valid_m) check($sformatf("b2b%0d_err", i), 32'(rsp_err_m), 32'd0);
      if (req_ready_m) begin
        req_addr = 32'h20 + 32'(4 * k);
        req_wdata = 32'hA0000000 + 32'(k);
        req_valid = 1'b1;
        $display("ws0 b2b cycle %0d store addr=%h data=%h", i, req_addr, req_wdata);
        k++;
      end else begin
        $display("ws0 b2b cycle %0d response valid=%0b", i, rsp_valid_m);
      end
      if (i == 7) req_valid = 1'b0;
    end
    for (int j = 0; j < 4; j++) begin
      txn(1'b0, FUNCT3_LW, 32'h20 + 32'(4 * j), 32'h0, rd, er, lat);
      $display("ws0 LW %h -> rdata=%h err=%0b lat=%0d", 32'h20 + 32'(4 * j), rd, er, lat);
      check($sformatf("ws0_lw%0d_rdata", j), rd, 32'hA0000000 + 32'(j));
      check($sformatf("ws0_lw%0d_lat", j), 32'(lat), 32'd1);
    end
    txn(1'b1, FUNCT3_LH, 32'h22, 32'h0000BEEF, rd, er, lat);
    $display("ws0 SH 0x22 -> rdata=%h err=%0b lat=%0d", rd, er, lat);
    check("ws0_sh_lat", 32'(lat), 32'd1);
    txn(1'b0, FUNCT3_LW, 32'h20, 32'h0, rd, er, lat);
    $display("ws0 LW 0x20 -> rdata=%h err=%0b lat=%0d", rd, er, lat);
    check("ws0_sh_merge", rd, 32'hBEEF0000);
    txn(1'b0, FUNCT3_LH, 32'h21, 32'h0, rd, er, lat);
    $display("ws0 LH 0x21 -> rdata=%h err=%0b lat=%0d", rd, er, lat);
    check("ws0_misalign_err", 32'(er), 32'd1);
    check("ws0_misalign_rdata", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
